// File: rtl/block_ring_buffer.sv
// rtl/block_ring_buffer.sv - block-framed circular word buffer between a card stream and a host word port
module block_ring_buffer #(
  parameter int NumWords        = 256,
  parameter int DataWidth       = 32,
  parameter int MaxBlockBitSize = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          dir_read_i,
  input  logic [MaxBlockBitSize-1:0]    block_size_i,
  input  logic [15:0]                   block_count_i,
  input  logic                          multi_block_i,
  input  logic                          block_count_en_i,
  input  logic                          card_valid_i,
  input  logic [DataWidth-1:0]          card_data_i,
  output logic                          card_ready_o,
  output logic                          buf_valid_o,
  output logic [DataWidth-1:0]          buf_data_o,
  input  logic                          buf_ready_i,
  input  logic                          host_we_i,
  input  logic [DataWidth-1:0]          host_wdata_i,
  input  logic                          host_re_i,
  output logic [DataWidth-1:0]          host_rdata_o,
  output logic                          buffer_read_enable_o,
  output logic                          buffer_write_enable_o,
  output logic                          block_done_o,
  output logic                          xfer_done_o,
  output logic [15:0]                   blocks_remaining_o,
  output logic [$clog2(NumWords+1)-1:0] level_o,
  output logic                          err_o
);
  localparam int AddrW     = $clog2(NumWords);
  localparam int LevelW    = $clog2(NumWords + 1);
  localparam int CntW      = MaxBlockBitSize + 1;
  localparam int CmpW      = (CntW > LevelW) ? CntW : LevelW;
  localparam int ByteShift = $clog2(DataWidth / 8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic                 r_dir_read;
  logic                 r_bounded;
  logic [CntW-1:0]      r_wpb;
  logic [15:0]          r_blocks_rem;
  logic [15:0]          r_card_rem;
  logic [CntW-1:0]      r_host_cnt;
  logic [CntW-1:0]      r_card_cnt;
  logic                 r_block_done;
  logic                 r_err;
  logic [AddrW-1:0]     r_wr_ptr;
  logic [AddrW-1:0]     r_rd_ptr;
  logic [LevelW-1:0]    r_level;
  logic [DataWidth-1:0] r_mem [NumWords];

  logic [CntW-1:0]      w_wpb_in;
  logic [LevelW-1:0]    w_free;
  logic                 w_busy;
  logic                 w_host_idle;
  logic                 w_rd_ok;
  logic                 w_wr_ok;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_host_acc;
  logic                 w_card_acc;
  logic                 w_host_err;
  logic                 w_start;
  logic                 w_flush;
  logic [15:0]          w_total;
  logic [15:0]          w_prod_rem;
  logic                 w_cons_idle;
  logic [DataWidth-1:0] w_head;
  logic [DataWidth-1:0] w_wdata;

  // Partial final words round up to a whole word.
  assign w_wpb_in    = (CntW'(block_size_i) + CntW'(DataWidth / 8 - 1)) >> ByteShift;
  assign w_free      = LevelW'(NumWords) - r_level;
  assign w_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_host_idle = (r_host_cnt == '0);
  assign w_total     = multi_block_i ? block_count_i : 16'd1;
  assign w_start     = start_i && (r_state == S_IDLE);
  assign w_flush     = abort_i || w_start;

  assign buffer_read_enable_o  = r_dir_read && w_busy && (CmpW'(r_level) >= CmpW'(r_wpb))
                                 && w_host_idle && !r_block_done;
  assign buffer_write_enable_o = !r_dir_read && (r_state == S_RUN) && (CmpW'(w_free) >= CmpW'(r_wpb))
                                 && w_host_idle && !r_block_done && (!r_bounded || r_blocks_rem != 16'd0);
  assign card_ready_o = r_dir_read && (r_state == S_RUN) && (w_free != '0)
                        && (!r_bounded || r_card_rem != 16'd0);
  assign buf_valid_o  = !r_dir_read && w_busy && (r_level != '0);

  // Once a block has been opened by the enable, the host may finish it without re-qualification.
  assign w_rd_ok = r_dir_read && w_busy && (r_level != '0) && (buffer_read_enable_o || !w_host_idle);
  assign w_wr_ok = !r_dir_read && (r_state == S_RUN) && (w_free != '0)
                   && (buffer_write_enable_o || !w_host_idle);

  assign w_push     = r_dir_read ? (card_valid_i && card_ready_o) : (host_we_i && w_wr_ok);
  assign w_pop      = r_dir_read ? (host_re_i && w_rd_ok) : (buf_valid_o && buf_ready_i);
  assign w_host_acc = r_dir_read ? w_pop : w_push;
  assign w_card_acc = r_dir_read ? w_push : w_pop;
  assign w_host_err = (host_re_i && !w_rd_ok) || (host_we_i && !w_wr_ok);
  assign w_wdata    = r_dir_read ? card_data_i : host_wdata_i;

  assign w_prod_rem  = r_dir_read ? r_card_rem : r_blocks_rem;
  assign w_cons_idle = r_dir_read ? w_host_idle : (r_card_cnt == '0);

  assign w_head       = r_mem[r_rd_ptr];
  assign host_rdata_o = (r_dir_read && r_level != '0) ? w_head : '0;
  assign buf_data_o   = (!r_dir_read && r_level != '0) ? w_head : '0;

  assign block_done_o       = r_block_done;
  assign xfer_done_o        = (r_state == S_DONE);
  assign blocks_remaining_o = r_blocks_rem;
  assign level_o            = r_level;
  assign err_o              = r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i && !abort_i && w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_dir_read   <= 1'b0;
      r_bounded    <= 1'b0;
      r_wpb        <= '0;
      r_blocks_rem <= 16'd0;
      r_card_rem   <= 16'd0;
      r_host_cnt   <= '0;
      r_card_cnt   <= '0;
      r_block_done <= 1'b0;
      r_err        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
    end else begin
      if (abort_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i && block_size_i != '0) begin
              r_state <= (multi_block_i && block_count_en_i && block_count_i == 16'd0) ? S_DONE : S_RUN;
            end
          end
          S_RUN:   if (r_bounded && w_prod_rem == 16'd0) r_state <= S_DRAIN;
          S_DRAIN: if (r_level == '0 && w_cons_idle) r_state <= S_DONE;
          default: r_state <= S_IDLE;
        endcase
      end

      if (w_start) begin
        r_dir_read   <= dir_read_i;
        r_bounded    <= !multi_block_i || block_count_en_i;
        r_wpb        <= w_wpb_in;
        r_blocks_rem <= (multi_block_i && block_count_en_i && block_count_i == 16'd0) ? 16'd0 : w_total;
        r_card_rem   <= w_total;
        r_err        <= (block_size_i == '0) || w_host_err;
      end else begin
        r_err <= r_err || w_host_err;
      end

      if (w_flush) begin
        r_host_cnt   <= '0;
        r_card_cnt   <= '0;
        r_block_done <= 1'b0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_level      <= '0;
      end else begin
        r_block_done <= 1'b0;
        if (w_host_acc) begin
          if (r_host_cnt == r_wpb - CntW'(1)) begin
            r_host_cnt   <= '0;
            r_block_done <= 1'b1;
          end else begin
            r_host_cnt <= r_host_cnt + CntW'(1);
          end
        end
        if (r_block_done && r_bounded && r_blocks_rem != 16'd0) begin
          r_blocks_rem <= r_blocks_rem - 16'd1;
        end
        if (w_card_acc) begin
          if (r_card_cnt == r_wpb - CntW'(1)) begin
            r_card_cnt <= '0;
            if (r_dir_read && r_bounded && r_card_rem != 16'd0) r_card_rem <= r_card_rem - 16'd1;
          end else begin
            r_card_cnt <= r_card_cnt + CntW'(1);
          end
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LevelW'(1);
          2'b01:   r_level <= r_level - LevelW'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end
endmodule
